// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the multicycle CPU arithmetic units (div_unit, mult_unit).
package cpu_pkg;

  localparam int unsigned CPU_DATA_WIDTH = 32;

  // One quotient bit per clock, so the iteration count tracks the operand width.
  localparam int unsigned DIV_ITERS  = CPU_DATA_WIDTH;
  localparam int unsigned MULT_ITERS = CPU_DATA_WIDTH;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted  = {rem, quo[DATA_WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    rem_next = shifted[DATA_WIDTH-1:0];
    quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
    // The remainder never exceeds the divisor, so the difference fits DATA_WIDTH bits.
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider: quotient on LO, remainder on HI, one quotient bit per clock.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CPU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  DIV_control,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  divStop,
  output logic                  divZero
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  div_state_e            state_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic                  sa_q;
  logic                  sb_q;

  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;

  // The most negative value negates to itself, which reads correctly as unsigned 2^(W-1).
  always_comb begin
    abs_a = A[DATA_WIDTH-1] ? -A : A;
    abs_b = B[DATA_WIDTH-1] ? -B : B;
  end

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      divStop   <= 1'b0;
      divZero   <= 1'b0;
    end else begin
      divStop <= 1'b0;
      divZero <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (DIV_control) begin
            if (B == '0) begin
              divStop <= 1'b1;
              divZero <= 1'b1;
            end else begin
              sa_q      <= A[DATA_WIDTH-1];
              sb_q      <= B[DATA_WIDTH-1];
              quo_q     <= abs_a;
              divisor_q <= abs_b;
              rem_q     <= '0;
              count_q   <= '0;
              state_q   <= StRun;
            end
          end
        end
        StRun: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + 1'b1;
          if (count_q == CntW'(DATA_WIDTH - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          LO      <= (sa_q ^ sb_q) ? -quo_q : quo_q;
          HI      <= sa_q ? -rem_q : rem_q;
          divStop <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the multicycle CPU datapath. It sits beside the ALU, fed by the A/B operand registers.
- Started by the control unit's DIV_control strobe. Returns quotient on LO and remainder on HI, then pulses divStop.
- On a zero divisor it flags divZero, which the control unit uses to enter its divide-by-zero exception sequence.
- Uses restoring division, one quotient bit per clock, on operand magnitudes with a final sign-fix stage.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
DIV_control  input  1  start strobe; sampled only in IDLE
A  input  DATA_WIDTH  dividend (two's complement), latched at start
B  input  DATA_WIDTH  divisor (two's complement), latched at start
HI  output  DATA_WIDTH  remainder, registered
LO  output  DATA_WIDTH  quotient, registered
divStop  output  1  one-cycle done pulse
divZero  output  1  one-cycle divide-by-zero pulse, coincident with divStop

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; it is sampled on posedge clk and overrides everything.
- Reset values: state=IDLE, HI=0, LO=0, divStop=0, divZero=0, count=0, internal operand registers=0.
- IDLE: divStop and divZero are driven 0 unless set by this edge's start handling.
- Start in IDLE with B==0: the start edge sets divStop=1 and divZero=1. State stays IDLE, HI and LO are unchanged, and both pulses clear on the next edge.
- Start in IDLE with B!=0, on the start edge (edge 0):
  - latch sa=A[MSB], sb=B[MSB], |A| into the quotient shift register, |B| into the divisor register;
  - remainder=0, count=0;
  - state goes to RUN.
- Absolute value is two's-complement negate when the MSB is set; |0x80000000| is treated as unsigned 2^31.
- RUN, one iteration per edge (edges 1..DATA_WIDTH):
  - shift {rem,quo} left by 1;
  - if rem_shifted >= divisor (unsigned, DATA_WIDTH+1-bit compare), then rem -= divisor and quo[0]=1, else quo[0]=0;
  - count++;
  - on the edge where count==DATA_WIDTH-1, state goes to FIX.
- FIX (edge DATA_WIDTH+1 = edge 33):
  - LO = (sa^sb) ? -quo : quo;
  - HI = sa ? -rem : rem;
  - divStop=1, state goes to IDLE.
- Total latency: divStop is visible for exactly one cycle, starting after the 33rd edge following the start-sampling edge.
- Result semantics (MIPS): quotient truncates toward zero; the remainder takes the dividend's sign.
- -2^31 / -1 gives LO=0x80000000, HI=0, with no flag.
- DIV_control asserted in RUN or FIX is ignored; there is no queuing.
- DIV_control held high continuously restarts on the first IDLE edge after FIX.
- A and B may change after the start edge without affecting the result.
- HI and LO hold their last values outside FIX and reset. They update only in FIX and never during RUN.
- Reset in RUN or FIX aborts the operation: HI=LO=0, no divStop is generated, and a subsequent start behaves normally.

Decomposition:
- Shared package (cpu_pkg): DATA_WIDTH default, div state encodings (IDLE=2'd0, RUN=2'd1, FIX=2'd2), and the iteration count constant.
- The same package supplies the future mult_unit with its shared constants.
- One sub-module is natural: div_step, a combinational restoring step taking {rem,quo} and the divisor and returning the next {rem,quo}. Everything else stays in div_unit.

Test Plan:
1. A=100, B=7, one-cycle DIV_control -> LO=14, HI=2; divStop high exactly one cycle after edge 33; divZero stays 0.
2. A=0xFFFFFF9C (-100), B=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2). Then A=100, B=0xFFFFFFF9 (-7) -> LO=0xFFFFFFF2, HI=2.
3. Preload HI/LO via test 1, then A=5, B=0 -> divZero=divStop=1 for one cycle right after the start edge; HI=2, LO=14 unchanged; state returns to IDLE.
4. A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. A=0, B=9 -> LO=0, HI=0. A=6, B=7 -> LO=0, HI=6.
5. Start A=100, B=7; change A/B and pulse DIV_control at RUN edge 5 -> results are still 14/2 with a single divStop at edge 33.
6. Assert reset at RUN edge 10 -> HI=LO=0, divStop never fires. Then start A=50, B=8 -> LO=6, HI=2 at edge 33.
